reg_busy_scoreboard: RTL and testbench

Parametrised register-busy scoreboard for the MIPS core, built around a generalised N-to-2^N one-hot decoder. It marks a destination register busy when an instruction issues and clears it when that register is written back. It also reports busy status for two source operands. In addition it produces a registered one-hot register-file write-enable vector. It sits between decode/issue and the register file and replaces the fixed 4-to-16 decode with a width-generic, stateful block.

---
 rtl/reg_busy_scoreboard_pkg.sv | 17 +
 rtl/reg_busy_scoreboard_decoder.sv | 19 +
 rtl/reg_busy_scoreboard.sv | 91 +++++++++
 tb/tb_reg_busy_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_busy_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: default register-address
// width and a one-hot helper sized for that default width.
//   REG_ADDR_W : default register-address width (32 architectural registers)
//   onehot()   : address -> one-hot vector of 2**REG_ADDR_W bits
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_NREG   = 2**REG_ADDR_W;

   function automatic logic [REG_NREG-1:0] onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [REG_NREG-1:0] v;
      v       = '0;
      v[addr] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/reg_busy_scoreboard_decoder.sv
// Generic N-to-2^N one-hot decoder with enable.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: addr_i (ADDR_W) address, en_i gates the output, dec_o (2**ADDR_W) one-hot / zero.
module decoder_n
   import cpu_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [ADDR_W-1:0]      addr_i,
   input  logic                   en_i,
   output logic [2**ADDR_W-1:0]   dec_o
);

   always_comb begin
      dec_o         = '0;
      dec_o[addr_i] = en_i;
   end

endmodule

// File: rtl/reg_busy_scoreboard.sv
// Register-busy scoreboard: tracks pending writes per register, reports source
// operand hazards and emits a registered one-hot register-file write enable.
// Latency: set/clr -> busy/busy_cnt/we_onehot 1 cycle; clr -> rs_busy/rt_busy 0 cycles.
// Backpressure: none; one set and one clr strobe may arrive every cycle.
// Ports: clk, rst (async, active-high); set_valid/set_addr issue; clr_valid/clr_addr
//        writeback; rs_addr/rt_addr -> rs_busy/rt_busy; busy, busy_cnt, we_onehot, err.
module reg_busy_scoreboard
   import cpu_pkg::*;
#(
   parameter int ADDR_W         = REG_ADDR_W,
   parameter bit ZERO_HARDWIRED = 1'b1,
   localparam int NREG          = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_valid,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_valid,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic [NREG-1:0]   busy,
   output logic [ADDR_W:0]   busy_cnt,
   output logic [NREG-1:0]   we_onehot,
   output logic              err
);

   localparam int CW = ADDR_W + 1;
   // Register 0 is dropped from both decodes when it is hardwired.
   localparam logic [NREG-1:0] KEEP_MASK = ZERO_HARDWIRED ? ~NREG'(1) : '1;

   logic [NREG-1:0] set_raw, clr_raw, set_dec, clr_dec;
   logic [NREG-1:0] busy_q, busy_d, we_q, we_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            inc, dec;

   decoder_n #(.ADDR_W(ADDR_W)) u_set_dec (
      .addr_i (set_addr),
      .en_i   (set_valid),
      .dec_o  (set_raw)
   );

   decoder_n #(.ADDR_W(ADDR_W)) u_clr_dec (
      .addr_i (clr_addr),
      .en_i   (clr_valid),
      .dec_o  (clr_raw)
   );

   assign set_dec = set_raw & KEEP_MASK;
   assign clr_dec = clr_raw & KEEP_MASK;

   always_comb begin
      // Set after clear: a same-register set/clr leaves the bit pending.
      busy_d = (busy_q & ~clr_dec) | set_dec;
      we_d   = clr_dec;
      // Decodes are one-hot, so each side moves the count by at most one.
      inc    = |(set_dec & ~busy_q);
      dec    = |(clr_dec & busy_q & ~set_dec);
      cnt_d  = cnt_q + CW'(inc) - CW'(dec);
      err_d  = err_q
             | (|(set_dec & busy_q & ~clr_dec))
             | (|(clr_dec & ~busy_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         we_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         we_q   <= we_d;
         err_q  <= err_d;
      end
   end

   // Same-cycle writeback bypasses the busy bit; same-cycle issue is ignored.
   assign rs_busy = busy_q[rs_addr] & ~(clr_valid & (clr_addr == rs_addr));
   assign rt_busy = busy_q[rt_addr] & ~(clr_valid & (clr_addr == rt_addr));

   assign busy      = busy_q;
   assign busy_cnt  = cnt_q;
   assign we_onehot = we_q;
   assign err       = err_q;

endmodule

// File: tb/tb_reg_busy_scoreboard.sv
module tb_reg_busy_scoreboard;

   localparam int AW   = 5;
   localparam int NREG = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            set_valid = 1'b0, clr_valid = 1'b0;
   logic [AW-1:0]   set_addr = '0, clr_addr = '0, rs_addr = '0, rt_addr = '0;
   logic            rs_busy, rt_busy, err;
   logic [NREG-1:0] busy, we_onehot;
   logic [AW:0]     busy_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a set of pending registers, expressed as a bit array.
   bit            m_pend[NREG];
   bit            m_err;
   logic [31:0]   m_we;

   reg_busy_scoreboard #(.ADDR_W(AW), .ZERO_HARDWIRED(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .set_valid (set_valid),
      .set_addr  (set_addr),
      .clr_valid (clr_valid),
      .clr_addr  (clr_addr),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_busy   (rs_busy),
      .rt_busy   (rt_busy),
      .busy      (busy),
      .busy_cnt  (busy_cnt),
      .we_onehot (we_onehot),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      m_err = 1'b0;
      m_we  = '0;
   endfunction

   function automatic void model_step(bit sv, int sa, bit cv, int ca);
      bit s_ok, c_ok;
      s_ok = sv && (sa != 0);
      c_ok = cv && (ca != 0);
      if (s_ok && m_pend[sa] && !(c_ok && ca == sa)) m_err = 1'b1;
      if (c_ok && !m_pend[ca]) m_err = 1'b1;
      m_we = '0;
      if (c_ok) begin
         m_we[ca]   = 1'b1;
         m_pend[ca] = 1'b0;
      end
      if (s_ok) m_pend[sa] = 1'b1;
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic int exp_cnt();
      int c;
      c = 0;
      for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic logic exp_src(int a);
      return m_pend[a] && !(clr_valid && int'(clr_addr) == a);
   endfunction

   task automatic apply(bit sv, int sa, bit cv, int ca, int ra, int ta);
      set_valid = sv;  set_addr = AW'(sa);
      clr_valid = cv;  clr_addr = AW'(ca);
      rs_addr   = AW'(ra);
      rt_addr   = AW'(ta);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(set_valid, int'(set_addr), clr_valid, int'(clr_addr));
      #1;
   endtask

   task automatic do_reset();
      apply(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      apply(0, 0, 0, 0, 5, 9);
      rst = 1'b1;
      #2;
      n_checks++; if (busy !== 32'h0)      begin n_errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
      n_checks++; if (busy_cnt !== 6'd0)   begin n_errors++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
      n_checks++; if (we_onehot !== 32'h0) begin n_errors++; $display("FAIL reset_we got=%h exp=0", we_onehot); end
      n_checks++; if (err !== 1'b0)        begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
      do_reset();
      tick(); tick();
      n_checks++; if (busy !== 32'h0 || busy_cnt !== 6'd0 || we_onehot !== 32'h0 || err !== 1'b0) begin
         n_errors++; $display("FAIL idle busy=%h cnt=%0d we=%h err=%b exp all 0", busy, busy_cnt, we_onehot, err);
      end
   endtask

   task automatic test_set_two();
      apply(1, 5, 0, 0, 0, 0); tick();
      apply(1, 9, 0, 0, 9, 4); tick();
      apply(0, 0, 0, 0, 9, 4); #1;
      n_checks++; if (busy !== 32'h0000_0220) begin n_errors++; $display("FAIL set2_busy got=%h exp=00000220", busy); end
      n_checks++; if (busy_cnt !== 6'd2)      begin n_errors++; $display("FAIL set2_cnt got=%0d exp=2", busy_cnt); end
      n_checks++; if (rs_busy !== 1'b1)       begin n_errors++; $display("FAIL set2_rs9 got=%b exp=1", rs_busy); end
      n_checks++; if (rt_busy !== 1'b0)       begin n_errors++; $display("FAIL set2_rt4 got=%b exp=0", rt_busy); end
   endtask

   task automatic test_clr_bypass();
      apply(0, 0, 1, 5, 5, 9); #1;
      n_checks++; if (rs_busy !== 1'b0) begin n_errors++; $display("FAIL bypass_rs5 got=%b exp=0", rs_busy); end
      n_checks++; if (rt_busy !== 1'b1) begin n_errors++; $display("FAIL bypass_rt9 got=%b exp=1", rt_busy); end
      tick();
      apply(0, 0, 0, 0, 5, 0);
      n_checks++; if (busy[5] !== 1'b0)           begin n_errors++; $display("FAIL clr5_busy got=%b exp=0", busy[5]); end
      n_checks++; if (we_onehot !== 32'h0000_0020) begin n_errors++; $display("FAIL clr5_we got=%h exp=00000020", we_onehot); end
      n_checks++; if (busy_cnt !== 6'd1)           begin n_errors++; $display("FAIL clr5_cnt got=%0d exp=1", busy_cnt); end
      tick();
      n_checks++; if (we_onehot !== 32'h0) begin n_errors++; $display("FAIL clr5_we_pulse got=%h exp=0", we_onehot); end
   endtask

   task automatic test_same_set_clr();
      apply(1, 7, 0, 0, 0, 0); tick();
      apply(1, 7, 1, 7, 7, 0); tick();
      apply(0, 0, 0, 0, 0, 0);
      n_checks++; if (busy[7] !== 1'b1)            begin n_errors++; $display("FAIL sc7_busy got=%b exp=1", busy[7]); end
      n_checks++; if (busy_cnt !== 6'd2)           begin n_errors++; $display("FAIL sc7_cnt got=%0d exp=2", busy_cnt); end
      n_checks++; if (err !== 1'b0)                begin n_errors++; $display("FAIL sc7_err got=%b exp=0", err); end
      n_checks++; if (we_onehot !== 32'h0000_0080) begin n_errors++; $display("FAIL sc7_we got=%h exp=00000080", we_onehot); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      apply(1, 0, 1, 0, 0, 0); #1;
      n_checks++; if (rs_busy !== 1'b0) begin n_errors++; $display("FAIL zero_rs got=%b exp=0", rs_busy); end
      tick();
      apply(0, 0, 0, 0, 0, 0); #1;
      n_checks++; if (busy !== 32'h0 || busy_cnt !== 6'd0) begin n_errors++; $display("FAIL zero_busy busy=%h cnt=%0d exp 0/0", busy, busy_cnt); end
      n_checks++; if (we_onehot !== 32'h0) begin n_errors++; $display("FAIL zero_we got=%h exp=0", we_onehot); end
      n_checks++; if (err !== 1'b0)        begin n_errors++; $display("FAIL zero_err got=%b exp=0", err); end
      n_checks++; if (rs_busy !== 1'b0)    begin n_errors++; $display("FAIL zero_rs_after got=%b exp=0", rs_busy); end
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(1, 4, 0, 0, 0, 0); tick();
      apply(1, 5, 0, 0, 0, 0); tick();
      apply(0, 0, 0, 0, 5, 4); #1;
      n_checks++; if (busy !== 32'h0000_0030 || rs_busy !== 1'b1) begin
         n_errors++; $display("FAIL pre_arst busy=%h rs=%b exp 00000030/1", busy, rs_busy);
      end
      rst = 1'b1; #1;   // mid-cycle, no clock edge in between
      model_clear();
      n_checks++; if (busy !== 32'h0 || busy_cnt !== 6'd0) begin n_errors++; $display("FAIL arst_busy busy=%h cnt=%0d exp 0/0", busy, busy_cnt); end
      n_checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin n_errors++; $display("FAIL arst_src rs=%b rt=%b exp 0/0", rs_busy, rt_busy); end
      n_checks++; if (err !== 1'b0 || we_onehot !== 32'h0) begin n_errors++; $display("FAIL arst_misc err=%b we=%h exp 0/0", err, we_onehot); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_err();
      do_reset();
      apply(0, 0, 1, 3, 0, 0); tick();
      apply(1, 12, 0, 0, 0, 0);
      n_checks++; if (err !== 1'b1)      begin n_errors++; $display("FAIL err_clr3 got=%b exp=1", err); end
      n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL err_clr3_cnt got=%0d exp=0", busy_cnt); end
      tick();
      apply(1, 12, 0, 0, 0, 0); tick();
      apply(0, 0, 0, 0, 0, 0); tick(); tick();
      n_checks++; if (busy_cnt !== 6'd1)           begin n_errors++; $display("FAIL dbl12_cnt got=%0d exp=1", busy_cnt); end
      n_checks++; if (busy !== 32'h0000_1000)       begin n_errors++; $display("FAIL dbl12_busy got=%h exp=00001000", busy); end
      n_checks++; if (err !== 1'b1)                 begin n_errors++; $display("FAIL err_sticky got=%b exp=1", err); end
      do_reset();
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_rst got=%b exp=0", err); end
   endtask

   task automatic test_random();
      int q[$];
      int sa, ca, ra, ta;
      bit sv, cv;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 75 == 74) do_reset();
         q.delete();
         for (int i = 0; i < NREG; i++) if (m_pend[i]) q.push_back(i);
         sv = ($urandom_range(0, 9) < 6);
         cv = ($urandom_range(0, 9) < 5);
         sa = $urandom_range(0, NREG-1);
         if (q.size() > 0 && $urandom_range(0, 9) < 8) ca = q[$urandom_range(0, q.size()-1)];
         else ca = $urandom_range(0, NREG-1);
         if ($urandom_range(0, 9) == 0) sa = ca;
         ra = ($urandom_range(0, 3) == 0) ? ca : $urandom_range(0, NREG-1);
         ta = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[$urandom_range(0, q.size()-1)] : $urandom_range(0, NREG-1);
         apply(sv, sa, cv, ca, ra, ta); #1;
         n_checks++; if (rs_busy !== exp_src(ra)) begin n_errors++; $display("FAIL rnd_rs cyc=%0d a=%0d got=%b exp=%b", cyc, ra, rs_busy, exp_src(ra)); end
         n_checks++; if (rt_busy !== exp_src(ta)) begin n_errors++; $display("FAIL rnd_rt cyc=%0d a=%0d got=%b exp=%b", cyc, ta, rt_busy, exp_src(ta)); end
         tick();
         n_checks++; if (busy !== exp_busy())          begin n_errors++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy, exp_busy()); end
         n_checks++; if (int'(busy_cnt) != exp_cnt())  begin n_errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, busy_cnt, exp_cnt()); end
         n_checks++; if (we_onehot !== m_we)           begin n_errors++; $display("FAIL rnd_we cyc=%0d got=%h exp=%h", cyc, we_onehot, m_we); end
         n_checks++; if (err !== m_err)                begin n_errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, m_err); end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_set_two();
      test_clr_bypass();
      test_same_set_clr();
      test_zero_reg();
      test_async_reset();
      test_err();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
